// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - shared card shoe with LFSR draw and round-robin grant arbitration
// Optional feature macro: DEALER_AUTO_SHUFFLE_EN (restock automatically on an empty-shoe request)
module card_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       req_player,
  input  logic       req_machine,
  output logic       grant_player,
  output logic       grant_machine,
  output logic       card_valid,
  output logic [4:0] card,
  output logic [3:0] card_rank,
  output logic [8:0] cards_left,
  output logic       deck_empty,
  output logic       busy
);

  localparam logic [4:0] RANK_FULL = 5'(4 * NUM_DECKS);
  localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);

  typedef enum logic [1:0] {IDLE, SEARCH, DEAL, RESTOCK} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [4:0]  count [13];
  logic [3:0]  rank_idx;    // probe index in SEARCH/DEAL, refill index in RESTOCK
  logic        winner;      // 1 = machine owns the draw in flight
  logic        last_grant;  // 1 = machine was granted most recently

  logic       any_req;
  logic       pick;
  logic [3:0] start_rank;

  assign any_req    = req_player | req_machine;
  // Both requesting: favour whoever was not served last
  assign pick       = (req_player & req_machine) ? ~last_grant : req_machine;
  // Fold 13..15 onto 0..2 so every LFSR nibble names a rank
  assign start_rank = (lfsr[3:0] > 4'd12) ? (lfsr[3:0] - 4'd13) : lfsr[3:0];
  assign deck_empty = (cards_left == 9'd0);

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Dealer FSM: arbitration, rank search, deal bookkeeping and restock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rank_idx      <= 4'd0;
      winner        <= 1'b0;
      last_grant    <= 1'b1;
      cards_left    <= SHOE_FULL;
      grant_player  <= 1'b0;
      grant_machine <= 1'b0;
      card_valid    <= 1'b0;
      card          <= 5'd0;
      card_rank     <= 4'd0;
      busy          <= 1'b0;
      for (int i = 0; i < 13; i++) count[i] <= RANK_FULL;
    end else begin
      grant_player  <= 1'b0;
      grant_machine <= 1'b0;
      card_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (shuffle) begin
            state    <= RESTOCK;
            rank_idx <= 4'd0;
            busy     <= 1'b1;
          end else if (any_req && !deck_empty) begin
            winner   <= pick;
            rank_idx <= start_rank;
            state    <= SEARCH;
            busy     <= 1'b1;
          end
`ifdef DEALER_AUTO_SHUFFLE_EN
          else if (any_req) begin
            state    <= RESTOCK;
            rank_idx <= 4'd0;
            busy     <= 1'b1;
          end
`endif
        end
        SEARCH: begin
          if (count[rank_idx] != 5'd0) begin
            state         <= DEAL;
            grant_player  <= ~winner;
            grant_machine <= winner;
            card_valid    <= 1'b1;
            last_grant    <= winner;
            card_rank     <= rank_idx + 4'd1;
            card          <= (rank_idx >= 4'd9) ? 5'd10 : ({1'b0, rank_idx} + 5'd1);
          end else begin
            rank_idx <= (rank_idx == 4'd12) ? 4'd0 : (rank_idx + 4'd1);
          end
        end
        DEAL: begin
          count[rank_idx] <= count[rank_idx] - 5'd1;
          cards_left      <= cards_left - 9'd1;
          state           <= IDLE;
          busy            <= 1'b0;
        end
        RESTOCK: begin
          count[rank_idx] <= RANK_FULL;
          if (rank_idx == 4'd12) begin
            cards_left <= SHOE_FULL;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            rank_idx <= rank_idx + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - self-checking bench for card_dealer
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shuffle;
  logic       req_player;
  logic       req_machine;
  logic       grant_player;
  logic       grant_machine;
  logic       card_valid;
  logic [4:0] card;
  logic [3:0] card_rank;
  logic [8:0] cards_left;
  logic       deck_empty;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  card_dealer #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .shuffle(shuffle),
    .req_player(req_player), .req_machine(req_machine),
    .grant_player(grant_player), .grant_machine(grant_machine),
    .card_valid(card_valid), .card(card), .card_rank(card_rank),
    .cards_left(cards_left), .deck_empty(deck_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p;
    logic m;
    logic exp_gp;
    logic exp_gm;
    int   exp_left;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; shuffle = 1'b0; req_player = 1'b0; req_machine = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called #1 after an edge with the DUT in IDLE; returns #1 after the DEAL edge
  task automatic draw(input logic p, input logic m, input int min_lat, input int max_lat,
                      output logic gp, output logic gm, output int rank);
    int lat;
    int exp_card;
    req_player = p; req_machine = m;
    gp = 1'b0; gm = 1'b0; rank = 0; lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (grant_player || grant_machine) begin
        gp = grant_player; gm = grant_machine; rank = int'(card_rank); lat = i;
        break;
      end
    end
    req_player = 1'b0; req_machine = 1'b0;
    check("grant_within_bound", int'(lat != 0), 1);
    if (lat != 0) begin
      exp_card = (rank > 10) ? 10 : rank;
      check("card_valid_with_grant", int'(card_valid), 1);
      check("single_grant", int'(gp) + int'(gm), 1);
      check("rank_legal", int'(rank >= 1 && rank <= 13), 1);
      check("card_value", int'(card), exp_card);
      check("latency_range", int'(lat >= min_lat && lat <= max_lat), 1);
    end
    @(posedge clk); #1;
  endtask

  logic gp, gm;
  int   rank;
  int   hist [14];
  int   bc;
  logic saw;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 51};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 50};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 49};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 48};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 47};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 46};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 45};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 44};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 43};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 42};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 41};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 40};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 39};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 38};

    // Reset state
    do_reset();
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_deck_empty", int'(deck_empty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_player", int'(grant_player), 0);
    check("rst_grant_machine", int'(grant_machine), 0);
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_card", int'(card), 0);
    check("rst_card_rank", int'(card_rank), 0);

    // Arbitration table
    for (int v = 0; v < 14; v++) begin
      draw(vecs[v].p, vecs[v].m, 2, 14, gp, gm, rank);
      check($sformatf("vec%0d_grant_player", v), int'(gp), int'(vecs[v].exp_gp));
      check($sformatf("vec%0d_grant_machine", v), int'(gm), int'(vecs[v].exp_gm));
      check($sformatf("vec%0d_cards_left", v), int'(cards_left), vecs[v].exp_left);
    end

    // Drain a full shoe with the player alone
    do_reset();
    for (int r = 0; r < 14; r++) hist[r] = 0;
    for (int d = 0; d < 52; d++) begin
      draw(1'b1, 1'b0, 2, 14, gp, gm, rank);
      check("drain_grant_player", int'(gp), 1);
      if (rank >= 1 && rank <= 13) hist[rank]++;
    end
    for (int r = 1; r <= 13; r++) check($sformatf("rank%0d_seen", r), hist[r], 4);
    check("drain_cards_left", int'(cards_left), 0);
    check("drain_deck_empty", int'(deck_empty), 1);

`ifdef DEALER_AUTO_SHUFFLE_EN
    // Empty shoe with a pending request restocks on its own
    draw(1'b0, 1'b1, 15, 40, gp, gm, rank);
    check("auto_grant_machine", int'(gm), 1);
    check("auto_cards_left", int'(cards_left), 51);
`else
    // Empty shoe blocks the request until an explicit shuffle
    req_machine = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (grant_player || grant_machine || busy) saw = 1'b1;
    end
    check("empty_blocks_request", int'(saw), 0);
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    bc = 0;
    while (busy && bc < 30) begin
      bc++;
      @(posedge clk); #1;
    end
    check("restock_busy_cycles", bc, 13);
    check("restock_cards_left", int'(cards_left), 52);
    check("restock_deck_empty", int'(deck_empty), 0);
    draw(1'b0, 1'b1, 2, 14, gp, gm, rank);
    check("post_shuffle_grant_machine", int'(gm), 1);
    check("post_shuffle_cards_left", int'(cards_left), 51);
`endif

    // Reset while a draw is in SEARCH
    do_reset();
    draw(1'b1, 1'b0, 2, 14, gp, gm, rank);
    draw(1'b0, 1'b1, 2, 14, gp, gm, rank);
    check("pre_abort_cards_left", int'(cards_left), 50);
    req_player = 1'b1;
    @(posedge clk); #1;
    check("search_busy", int'(busy), 1);
    check("search_no_grant_yet", int'(grant_player), 0);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_grant_player", int'(grant_player), 0);
    check("abort_card_valid", int'(card_valid), 0);
    check("abort_card", int'(card), 0);
    check("abort_card_rank", int'(card_rank), 0);
    check("abort_cards_left", int'(cards_left), 52);
    req_player = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (grant_player || grant_machine || card_valid) saw = 1'b1;
    end
    check("abort_no_grant", int'(saw), 0);
    check("abort_release_cards_left", int'(cards_left), 52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
